// File: rtl/hazard_sequencer.sv
// hazard_sequencer: pipeline hazard control for the 5-stage LEGv8 core.
// Detects load-use and flag-use hazards between the Decode and Execute
// stages, sequences the resulting bubble cycles and the IF/ID flush after a
// taken branch, and keeps saturating debug counters for stalls and flushes.
// Hazard outputs are combinational so a hazard is signalled in the cycle it
// is decoded; only the state, stall counter and perf counters are registered.
module hazard_sequencer #(
   parameter int LOAD_LAT = 1,
   parameter int CNT_W    = 16
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic [31:0]      Reg_instruction,
   input  logic [31:0]      Ex_instruction,
   input  logic             BrTaken,
   output logic             pc_write_en,
   output logic             ifid_write_en,
   output logic             idex_bubble,
   output logic             ifid_flush,
   output logic             busy,
   output logic [CNT_W-1:0] stall_count,
   output logic [CNT_W-1:0] flush_count
);

   typedef enum logic [1:0] {
      ST_RUN   = 2'd0,
      ST_STALL = 2'd1,
      ST_FLUSH = 2'd2
   } state_t;

   // Extra bubbles after the one issued in RUN when the hazard is detected.
   localparam logic [2:0] LOAD_RELOAD = 3'(LOAD_LAT - 1);
   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

   // True when the Decode instruction is a branch that reads no Rn.
   function automatic logic f_is_branch(input logic [31:0] d);
      f_is_branch = (d[31:26] == 6'b000101) ||   // B
                    (d[31:26] == 6'b100101) ||   // BL
                    (d[31:24] == 8'h54)     ||   // B.cond
                    (d[31:24] == 8'hB4);         // CBZ
   endfunction

   // True for the R-type opcodes that also read Rm.
   function automatic logic f_is_rtype(input logic [10:0] op);
      f_is_rtype = (op == 11'h458) || (op == 11'h658) || (op == 11'h558) ||
                   (op == 11'h758) || (op == 11'h450) || (op == 11'h550);
   endfunction

   state_t     r_state;
   state_t     w_state_nxt;
   logic [2:0] r_stall_cnt;
   logic [2:0] w_stall_cnt_nxt;

   logic [CNT_W-1:0] r_stall_count;
   logic [CNT_W-1:0] r_flush_count;

   logic       w_d_branch;
   logic       w_rn_used;
   logic       w_rm_used;
   logic       w_rt_used;
   logic       w_e_load;
   logic       w_e_flags;
   logic [4:0] w_ld_dst;
   logic       w_load_use;
   logic       w_flag_use;

   logic       w_pc_we;
   logic       w_ifid_we;
   logic       w_bubble;
   logic       w_flush;

   // Instruction fields that no hazard rule looks at.
   logic       w_unused_bits;
   assign w_unused_bits = ^{Reg_instruction[15:10], Ex_instruction[20:5]};

   // Decode the Decode/Execute pair into load-use and flag-use hazards.
   always_comb begin
      w_d_branch = f_is_branch(Reg_instruction);
      w_rn_used  = !w_d_branch;
      w_rm_used  = f_is_rtype(Reg_instruction[31:21]);
      w_rt_used  = (Reg_instruction[31:21] == 11'h7C0) ||
                   (Reg_instruction[31:24] == 8'hB4);
      w_e_load   = (Ex_instruction[31:21] == 11'h7C2);
      w_e_flags  = (Ex_instruction[31:21] == 11'h558) ||
                   (Ex_instruction[31:21] == 11'h758);
      w_ld_dst   = Ex_instruction[4:0];
      // A destination of XZR can never match, so source XZR never stalls.
      w_load_use = w_e_load && (w_ld_dst != 5'd31) &&
                   ((w_rn_used && (Reg_instruction[9:5]   == w_ld_dst)) ||
                    (w_rm_used && (Reg_instruction[20:16] == w_ld_dst)) ||
                    (w_rt_used && (Reg_instruction[4:0]   == w_ld_dst)));
      w_flag_use = (Reg_instruction[31:24] == 8'h54) && w_e_flags;
   end

   // Next-state, stall reload and pipeline-control outputs.
   always_comb begin
      w_state_nxt     = r_state;
      w_stall_cnt_nxt = r_stall_cnt;
      w_pc_we         = 1'b1;
      w_ifid_we       = 1'b1;
      w_bubble        = 1'b0;
      w_flush         = 1'b0;
      case (r_state)
         ST_RUN: begin
            if (w_load_use || w_flag_use) begin
               // An unresolved branch waiting on its operand: ignore BrTaken.
               w_pc_we         = 1'b0;
               w_ifid_we       = 1'b0;
               w_bubble        = 1'b1;
               w_stall_cnt_nxt = w_load_use ? LOAD_RELOAD : 3'd0;
               w_state_nxt     = (w_stall_cnt_nxt != 3'd0) ? ST_STALL : ST_RUN;
            end else if (BrTaken) begin
               w_flush     = 1'b1;
               w_state_nxt = ST_FLUSH;
            end else begin
               w_state_nxt = ST_RUN;
            end
         end
         ST_STALL: begin
            w_pc_we         = 1'b0;
            w_ifid_we       = 1'b0;
            w_bubble        = 1'b1;
            w_stall_cnt_nxt = r_stall_cnt - 3'd1;
            if (w_stall_cnt_nxt == 3'd0) begin
               w_state_nxt = ST_RUN;
            end else begin
               w_state_nxt = ST_STALL;
            end
         end
         ST_FLUSH: begin
            // Decode holds the flushed NOP; nothing to act on this cycle.
            w_state_nxt = ST_RUN;
         end
         default: begin
            w_state_nxt     = ST_RUN;
            w_stall_cnt_nxt = 3'd0;
         end
      endcase
   end

   // State and stall-counter registers.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state     <= ST_RUN;
         r_stall_cnt <= 3'd0;
      end else begin
         r_state     <= w_state_nxt;
         r_stall_cnt <= w_stall_cnt_nxt;
      end
   end

   // Saturating debug counters for bubble cycles and flushes.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_stall_count <= {CNT_W{1'b0}};
         r_flush_count <= {CNT_W{1'b0}};
      end else begin
         if (w_bubble && (r_stall_count != CNT_MAX)) begin
            r_stall_count <= r_stall_count + CNT_ONE;
         end
         if (w_flush && (r_flush_count != CNT_MAX)) begin
            r_flush_count <= r_flush_count + CNT_ONE;
         end
      end
   end

   assign pc_write_en   = w_pc_we;
   assign ifid_write_en = w_ifid_we;
   assign idex_bubble   = w_bubble;
   assign ifid_flush    = w_flush;
   assign busy          = (r_state != ST_RUN);
   assign stall_count   = r_stall_count;
   assign flush_count   = r_flush_count;

endmodule

// File: tb/tb_hazard_sequencer.sv
// Directed bench for hazard_sequencer: a vector table on a LOAD_LAT=1 /
// CNT_W=16 instance, plus hand sequences on a LOAD_LAT=3 / CNT_W=4 instance
// for multi-cycle stalls, asynchronous reset mid-stall and counter saturation.
module tb_hazard_sequencer;

   // Instruction encodings used by the vectors.
   localparam logic [31:0] NOP0      = 32'h0000_0000;
   localparam logic [31:0] LDUR_X2   = 32'hF840_0022; // LDUR X2,[X1]
   localparam logic [31:0] LDUR_X1   = 32'hF840_0021; // LDUR X1,[X1]
   localparam logic [31:0] LDUR_X31  = 32'hF840_003F; // LDUR XZR,[X1]
   localparam logic [31:0] ADD_RN2   = 32'h8B04_0043; // ADD X3,X2,X4
   localparam logic [31:0] ADD_RM2   = 32'h8B02_00A3; // ADD X3,X5,X2
   localparam logic [31:0] ADD_RD2   = 32'h8B06_00A2; // ADD X2,X5,X6
   localparam logic [31:0] ADD_XZR   = 32'h8B1F_03E3; // ADD X3,XZR,XZR
   localparam logic [31:0] AND_RM2   = 32'h8A02_00A3; // AND X3,X5,X2
   localparam logic [31:0] ADDI_IMM  = 32'h9102_00A3; // ADDI X3,X5,#0x80
   localparam logic [31:0] STUR_X2   = 32'hF800_00A2; // STUR X2,[X5]
   localparam logic [31:0] CBZ_X2    = 32'hB400_0022; // CBZ X2 (Rn field = 1)
   localparam logic [31:0] BLT       = 32'h5400_004B; // B.LT (Rn field = 2)
   localparam logic [31:0] SUBS_I    = 32'hEB03_0041; // SUBS X1,X2,X3
   localparam logic [31:0] ADDS_I    = 32'hAB03_0041; // ADDS X1,X2,X3
   localparam logic [31:0] B_UNC     = 32'h1400_0010; // B +16

   logic clk;
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Instance A: default parameters.
   logic        a_rst_n, a_br;
   logic [31:0] a_d, a_e;
   logic        a_pc, a_ifid, a_bub, a_fl, a_busy;
   logic [15:0] a_scnt, a_fcnt;

   // Instance B: LOAD_LAT = 3, CNT_W = 4.
   logic        b_rst_n, b_br;
   logic [31:0] b_d, b_e;
   logic        b_pc, b_ifid, b_bub, b_fl, b_busy;
   logic [3:0]  b_scnt, b_fcnt;

   hazard_sequencer #(.LOAD_LAT(1), .CNT_W(16)) dut_a (
      .clk(clk), .reset_n(a_rst_n),
      .Reg_instruction(a_d), .Ex_instruction(a_e), .BrTaken(a_br),
      .pc_write_en(a_pc), .ifid_write_en(a_ifid), .idex_bubble(a_bub),
      .ifid_flush(a_fl), .busy(a_busy),
      .stall_count(a_scnt), .flush_count(a_fcnt)
   );

   hazard_sequencer #(.LOAD_LAT(3), .CNT_W(4)) dut_b (
      .clk(clk), .reset_n(b_rst_n),
      .Reg_instruction(b_d), .Ex_instruction(b_e), .BrTaken(b_br),
      .pc_write_en(b_pc), .ifid_write_en(b_ifid), .idex_bubble(b_bub),
      .ifid_flush(b_fl), .busy(b_busy),
      .stall_count(b_scnt), .flush_count(b_fcnt)
   );

   typedef struct {
      logic [31:0] d;
      logic [31:0] e;
      logic        br;
      logic [4:0]  exp_ctl;   // {pc_we, ifid_we, bubble, flush, busy}
      logic [15:0] exp_scnt;
      logic [15:0] exp_fcnt;
   } vec_t;

   localparam int NV = 23;
   vec_t vecs [NV];

   int n_applied;
   int n_miss;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_applied++;
      if (act !== exp) begin
         n_miss++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   function automatic vec_t mk(input logic [31:0] d, input logic [31:0] e, input logic br,
                               input logic [4:0] ctl, input logic [15:0] s, input logic [15:0] f);
      vec_t v;
      v.d = d; v.e = e; v.br = br; v.exp_ctl = ctl; v.exp_scnt = s; v.exp_fcnt = f;
      return v;
   endfunction

   int nb;

   initial begin
      n_applied = 0;
      n_miss    = 0;
      // Expected values are those seen before the clock edge of each row.
      vecs[0]  = mk(NOP0,     NOP0,     1'b0, 5'b11000, 16'd0, 16'd0);
      vecs[1]  = mk(ADD_RN2,  LDUR_X2,  1'b0, 5'b00100, 16'd0, 16'd0); // Rn load-use
      vecs[2]  = mk(ADD_RN2,  NOP0,     1'b0, 5'b11000, 16'd1, 16'd0);
      vecs[3]  = mk(ADD_XZR,  LDUR_X31, 1'b0, 5'b11000, 16'd1, 16'd0); // XZR exempt
      vecs[4]  = mk(ADD_RM2,  LDUR_X2,  1'b0, 5'b00100, 16'd1, 16'd0); // Rm load-use
      vecs[5]  = mk(ADDI_IMM, LDUR_X2,  1'b0, 5'b11000, 16'd2, 16'd0); // I-type: no Rm
      vecs[6]  = mk(STUR_X2,  LDUR_X2,  1'b0, 5'b00100, 16'd2, 16'd0); // STUR Rt
      vecs[7]  = mk(CBZ_X2,   LDUR_X1,  1'b0, 5'b11000, 16'd3, 16'd0); // CBZ: no Rn
      vecs[8]  = mk(CBZ_X2,   LDUR_X2,  1'b0, 5'b00100, 16'd3, 16'd0); // CBZ Rt
      vecs[9]  = mk(ADD_RD2,  LDUR_X2,  1'b0, 5'b11000, 16'd4, 16'd0); // Rd only
      vecs[10] = mk(AND_RM2,  LDUR_X2,  1'b0, 5'b00100, 16'd4, 16'd0); // AND Rm
      vecs[11] = mk(ADD_RN2,  ADDS_I,   1'b0, 5'b11000, 16'd5, 16'd0); // flags, no B.cond
      vecs[12] = mk(BLT,      SUBS_I,   1'b1, 5'b00100, 16'd5, 16'd0); // flag-use, Br ignored
      vecs[13] = mk(BLT,      NOP0,     1'b1, 5'b11010, 16'd6, 16'd0); // now flush
      vecs[14] = mk(NOP0,     NOP0,     1'b1, 5'b11001, 16'd6, 16'd1); // FLUSH, Br ignored
      vecs[15] = mk(B_UNC,    NOP0,     1'b1, 5'b11010, 16'd6, 16'd1); // taken B
      vecs[16] = mk(ADD_RN2,  LDUR_X2,  1'b0, 5'b11001, 16'd6, 16'd2); // FLUSH hides hazard
      vecs[17] = mk(ADD_RN2,  LDUR_X2,  1'b0, 5'b00100, 16'd6, 16'd2);
      vecs[18] = mk(NOP0,     NOP0,     1'b0, 5'b11000, 16'd7, 16'd2);
      vecs[19] = mk(BLT,      ADDS_I,   1'b0, 5'b00100, 16'd7, 16'd2); // ADDS flag-use
      vecs[20] = mk(NOP0,     NOP0,     1'b0, 5'b11000, 16'd8, 16'd2);
      vecs[21] = mk(BLT,      LDUR_X2,  1'b0, 5'b11000, 16'd8, 16'd2); // B.cond reads no Rn
      vecs[22] = mk(NOP0,     NOP0,     1'b0, 5'b11000, 16'd8, 16'd2);

      a_rst_n = 1'b0; a_d = NOP0; a_e = NOP0; a_br = 1'b0;
      b_rst_n = 1'b0; b_d = NOP0; b_e = NOP0; b_br = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      a_rst_n = 1'b1;
      b_rst_n = 1'b1;

      // Reset state of both instances.
      @(negedge clk);
      chk("a_reset_ctl", {27'd0, a_pc, a_ifid, a_bub, a_fl, a_busy}, {27'd0, 5'b11000});
      chk("a_reset_scnt", {16'd0, a_scnt}, 32'd0);
      chk("a_reset_fcnt", {16'd0, a_fcnt}, 32'd0);
      chk("b_reset_ctl", {27'd0, b_pc, b_ifid, b_bub, b_fl, b_busy}, {27'd0, 5'b11000});

      // Table-driven vectors on instance A.
      for (int i = 0; i < NV; i++) begin
         @(posedge clk);
         #1;
         a_d  = vecs[i].d;
         a_e  = vecs[i].e;
         a_br = vecs[i].br;
         @(negedge clk);
         chk($sformatf("vec%0d_ctl", i), {27'd0, a_pc, a_ifid, a_bub, a_fl, a_busy},
             {27'd0, vecs[i].exp_ctl});
         chk($sformatf("vec%0d_scnt", i), {16'd0, a_scnt}, {16'd0, vecs[i].exp_scnt});
         chk($sformatf("vec%0d_fcnt", i), {16'd0, a_fcnt}, {16'd0, vecs[i].exp_fcnt});
      end

      // Instance B: LOAD_LAT=3 load-use, reset in the 2nd stall cycle.
      @(posedge clk);
      #1;
      b_d = ADD_RN2; b_e = LDUR_X2;
      @(negedge clk);
      chk("b_hz_ctl", {27'd0, b_pc, b_ifid, b_bub, b_fl, b_busy}, {27'd0, 5'b00100});
      @(posedge clk);
      #1;
      b_e = NOP0;
      @(negedge clk);
      chk("b_stall1_ctl", {27'd0, b_pc, b_ifid, b_bub, b_fl, b_busy}, {27'd0, 5'b00101});
      chk("b_stall1_scnt", {28'd0, b_scnt}, 32'd1);
      @(posedge clk);
      @(negedge clk);
      chk("b_stall2_ctl", {27'd0, b_pc, b_ifid, b_bub, b_fl, b_busy}, {27'd0, 5'b00101});
      chk("b_stall2_scnt", {28'd0, b_scnt}, 32'd2);
      #2;
      b_rst_n = 1'b0;
      #1;
      chk("b_async_rst_ctl", {27'd0, b_pc, b_ifid, b_bub, b_fl, b_busy}, {27'd0, 5'b11000});
      chk("b_async_rst_scnt", {28'd0, b_scnt}, 32'd0);
      b_d = NOP0;
      @(posedge clk);
      #1;
      b_rst_n = 1'b1;

      // Full LOAD_LAT=3 stall: exactly three bubble cycles.
      @(posedge clk);
      #1;
      b_d = ADD_RN2; b_e = LDUR_X2;
      nb = 0;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         if (b_bub) nb++;
         @(posedge clk);
         #1;
         b_e = NOP0;
      end
      @(negedge clk);
      chk("b_bubble_len", nb, 32'd3);
      chk("b_full_scnt", {28'd0, b_scnt}, 32'd3);
      chk("b_back_to_run", {31'd0, b_busy}, 32'd0);

      // Back-to-back taken branches: flush_count saturates at 15.
      @(posedge clk);
      #1;
      b_d = B_UNC; b_br = 1'b1;
      repeat (20) @(posedge clk);
      @(negedge clk);
      chk("b_fcnt_10", {28'd0, b_fcnt}, 32'd10);
      repeat (20) @(posedge clk);
      #1;
      b_br = 1'b0; b_d = NOP0;
      @(negedge clk);
      chk("b_fcnt_sat", {28'd0, b_fcnt}, 32'd15);
      chk("b_scnt_kept", {28'd0, b_scnt}, 32'd3);

      $display("== %0d vectors applied, %0d miscompares ==", n_applied, n_miss);
      $finish;
   end

endmodule

// File: doc/hazard_sequencer.md
Name: hazard_sequencer

Overview:
- Pipeline control block for the 5-stage LEGv8 core.
- Watches the instructions in the Decode and Execute stages. Detects load-use and flag-use hazards, and sequences the stall cycles they need.
- Sequences the IF/ID flush after a taken branch.
- Drives the PC/IF-ID write enables, the ID/EX bubble and the IF/ID flush. Keeps saturating stall and flush counters for debug.

Parameters:
- LOAD_LAT, 1, bubble cycles inserted per load-use hazard (1..7).
- CNT_W, 16, width of each performance counter.

Ports:
- clk  input  1  system clock, rising edge.
- reset_n  input  1  asynchronous active-low reset.
- Reg_instruction  input  32  instruction currently in Decode (IF/ID register).
- Ex_instruction  input  32  instruction currently in Execute (ID/EX register).
- BrTaken  input  1  branch resolved taken in Decode (from the branch/flag unit).
- pc_write_en  output  1  1 = PC may update.
- ifid_write_en  output  1  1 = IF/ID may load.
- idex_bubble  output  1  1 = load a NOP into ID/EX this cycle.
- ifid_flush  output  1  1 = clear IF/ID to NOP at the next edge.
- busy  output  1  1 = state is not RUN.
- stall_count  output  CNT_W  total bubble cycles since reset; saturates at all-ones.
- flush_count  output  CNT_W  total flushes since reset; saturates at all-ones.

Behaviour:
- Decode (combinational, on Reg_instruction = D and Ex_instruction = E):
  - E is a load when E[31:21] = 11'h7C2 (LDUR); the load destination is E[4:0].
  - E is flag-setting when E[31:21] = 11'h558 (ADDS) or 11'h758 (SUBS).
  - D reads Rn D[9:5] for all non-branch types.
  - D also reads Rm D[20:16] for R-type: D[31:21] in {458,658,558,758,450,550}.
  - D also reads Rt D[4:0] when it is STUR (7C0) or CBZ (D[31:24] = B4).
  - A source register of 31 (XZR) never causes a hazard.
  - load_use = E is LDUR, E[4:0] != 31, and E[4:0] equals any register D reads.
  - flag_use = D is B.cond (D[31:24] = 54) and E is flag-setting.
- State machine:
  - States: RUN, STALL, FLUSH.
  - Reset (reset_n = 0, asynchronous) -> RUN; stall counter = 0; both perf counters = 0.
- RUN:
  - Outputs: pc_write_en = 1, ifid_write_en = 1, idex_bubble = 0, ifid_flush = 0.
  - On load_use or flag_use, in the same cycle: pc_write_en = 0, ifid_write_en = 0, idex_bubble = 1.
    - Load stall count: LOAD_LAT - 1 for load_use, 0 for flag_use.
    - Next state: STALL if the loaded count is nonzero, otherwise RUN.
  - Else if BrTaken: ifid_flush = 1; flush_count increments; next state FLUSH.
  - Hazard has priority over BrTaken. A branch waiting on its operand is not resolved, so BrTaken is ignored that cycle.
- STALL:
  - pc_write_en = 0, ifid_write_en = 0, idex_bubble = 1.
  - Decrement the stall counter; go to RUN when the counter reaches 0 this cycle.
  - Hazard inputs and BrTaken are ignored.
- FLUSH:
  - Single cycle: all enables 1, idex_bubble = 0, ifid_flush = 0.
  - The flushed NOP is in Decode, so BrTaken and hazards are ignored.
  - Always returns to RUN.
- Counters:
  - stall_count increments on every cycle with idex_bubble = 1.
  - Both counters stick at 2^CNT_W - 1.
- Reset mid-stall or mid-flush: immediate return to the RUN output values, with no glitch beyond combinational settling.
- busy = (state != RUN).
- Latency: a hazard is signalled in the same cycle it is decoded, with zero cycles of latency. The total bubble length is exactly LOAD_LAT cycles (load) or 1 cycle (flag).

Test Plan:
- Load-use: E = LDUR X2,[X1] (Rt = 2), D = ADD X3,X2,X4 -> idex_bubble = 1 and pc_write_en = 0 for exactly LOAD_LAT cycles; stall_count = LOAD_LAT; then RUN.
- XZR exemption: E = LDUR with Rt = 31, D reads X31 -> no stall; stall_count stays 0.
- Flag hazard: E = SUBS (E[31:21] = 758), D = B.LT -> one bubble cycle; BrTaken = 1 that cycle is ignored (flush_count stays 0). The next cycle, D is still B.LT, BrTaken = 1 -> ifid_flush = 1, flush_count = 1, state FLUSH, then RUN.
- Taken unconditional B in D, no hazard -> ifid_flush = 1 for 1 cycle; busy = 1 the following cycle; BrTaken held high during FLUSH adds no second flush.
- LOAD_LAT = 3: load-use, then reset_n pulled low in the 2nd stall cycle -> outputs return to RUN values asynchronously; stall_count = 0 after reset.
- CNT_W = 4: 20 back-to-back taken branches -> flush_count saturates at 15.
